// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: turns a W-bit intensity into a spike train over a window
// of 2^W steps. Deterministic mode spreads exactly v spikes evenly using an
// accumulator carry; stochastic mode fires when an LFSR sample is below v.
//
// state | meaning
// IDLE  | waiting for an intensity; in_ready high
// RUN   | one coding step per clock, 2^W steps total
// DONE  | window complete; window_done pulses for this one cycle
module spike_rate_encoder #(
   parameter int          W         = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         mode_stoch,
   input  logic         abort,
   output logic         spike_out,
   output logic         busy,
   output logic         window_done,
   output logic [W:0]   spike_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [W-1:0] STEP_LAST = {W{1'b1}};
   localparam logic [W:0]   CNT_MAX   = {(W+1){1'b1}};

   state_t       state_q, state_d;
   logic [W-1:0] v_q, v_d;
   logic         mode_q, mode_d;
   logic [W-1:0] acc_q, acc_d;
   logic [W-1:0] step_q, step_d;
   logic [W:0]   cnt_q, cnt_d;
   logic         spike_q, spike_d;
   logic [15:0]  lfsr_q, lfsr_d;

   logic         accept;
   logic [W:0]   sum;
   logic         step_spike;

   assign accept = in_valid && (state_q == IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort only matters once a window is running
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN: begin
            if (abort)                     state_d = IDLE;
            else if (step_q == STEP_LAST)  state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Decoded status outputs
   always_comb begin
      in_ready    = (state_q == IDLE);
      busy        = (state_q == RUN);
      window_done = (state_q == DONE);
   end

   // Coding step: carry of acc+v, or LFSR sample below v
   always_comb begin
      sum        = {1'b0, acc_q} + {1'b0, v_q};
      step_spike = mode_q ? (lfsr_q[W-1:0] < v_q) : sum[W];
   end

   // Datapath next values
   always_comb begin
      v_d     = v_q;
      mode_d  = mode_q;
      acc_d   = acc_q;
      step_d  = step_q;
      cnt_d   = cnt_q;
      spike_d = spike_q;
      lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      case (state_q)
         IDLE: begin
            spike_d = 1'b0;
            if (accept) begin
               v_d    = in_data;
               mode_d = mode_stoch;
               acc_d  = '0;
               step_d = '0;
               cnt_d  = '0;
            end
         end
         RUN: begin
            if (abort) begin
               spike_d = 1'b0;
            end else begin
               spike_d = step_spike;
               step_d  = step_q + 1'b1;
               if (!mode_q) acc_d = sum[W-1:0];
               if (step_spike && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    spike_d = 1'b0;
         default: spike_d = 1'b0;
      endcase
   end

   // Datapath registers; reset wins over every state action
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q     <= '0;
         mode_q  <= 1'b0;
         acc_q   <= '0;
         step_q  <= '0;
         cnt_q   <= '0;
         spike_q <= 1'b0;
         lfsr_q  <= LFSR_SEED;
      end else begin
         v_q     <= v_d;
         mode_q  <= mode_d;
         acc_q   <= acc_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         spike_q <= spike_d;
         lfsr_q  <= lfsr_d;
      end
   end

   assign spike_out = spike_q;
   assign spike_cnt = cnt_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Testbench for spike_rate_encoder: directed windows plus randomized windows,
// each step compared against an arithmetic reference model.
module tb_spike_rate_encoder;

   localparam int          W    = 8;
   localparam int          NSTP = 1 << W;
   localparam logic [15:0] SEED = 16'hACE1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         mode_stoch = 1'b0;
   logic         abort = 1'b0;
   logic         spike_out;
   logic         busy;
   logic         window_done;
   logic [W:0]   spike_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int n_acc    = 0;
   int n_acc_exp = 0;

   // reference LFSR: polynomial x^16+x^14+x^13+x^11+1, advanced every edge
   logic [15:0] m_lfsr = SEED;

   spike_rate_encoder #(.W(W), .LFSR_SEED(SEED)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .mode_stoch  (mode_stoch),
      .abort       (abort),
      .spike_out   (spike_out),
      .busy        (busy),
      .window_done (window_done),
      .spike_cnt   (spike_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   always @(posedge clk) begin
      m_lfsr <= rst ? SEED : lfsr_next(m_lfsr);
      if (!rst && in_valid && in_ready) n_acc <= n_acc + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one window. abort_step / rst_step < NSTP interrupt before that step.
   task automatic run_window(input logic [W-1:0] v, input bit mode, input int abort_step,
                             input int rst_step, input bit abort_at_accept, output int spikes);
      int  cnt;
      bit  exp_spike;
      int  lo, hi;
      cnt = 0;
      spikes = 0;
      check("ready_before_accept", in_ready, 1);
      in_valid = 1'b1; in_data = v; mode_stoch = mode; abort = abort_at_accept;
      tick();
      n_acc_exp++;
      in_valid = 1'($urandom); in_data = W'($urandom); mode_stoch = 1'($urandom); abort = 1'b0;
      check("accept_busy", busy, 1);
      check("accept_ready", in_ready, 0);
      check("accept_cnt_clear", spike_cnt, 0);
      for (int k = 0; k < NSTP; k++) begin
         if (mode) begin
            exp_spike = (int'(m_lfsr[W-1:0]) < int'(v));
         end else begin
            lo = (k * int'(v)) / NSTP;
            hi = ((k + 1) * int'(v)) / NSTP;
            exp_spike = (hi != lo);
         end
         if (k == abort_step) begin
            abort = 1'b1; in_valid = 1'b0;
            tick();
            abort = 1'b0;
            check("abort_ready", in_ready, 1);
            check("abort_spike", spike_out, 0);
            check("abort_no_done", window_done, 0);
            check("abort_cnt", spike_cnt, cnt);
            spikes = cnt;
            return;
         end
         if (k == rst_step) begin
            rst = 1'b1; in_valid = 1'b0;
            tick();
            rst = 1'b0;
            check("rst_spike", spike_out, 0);
            check("rst_done", window_done, 0);
            check("rst_busy", busy, 0);
            check("rst_cnt", spike_cnt, 0);
            check("rst_ready", in_ready, 1);
            spikes = 0;
            return;
         end
         in_valid = 1'($urandom); in_data = W'($urandom);
         tick();
         if (exp_spike && cnt < (1 << (W + 1)) - 1) cnt++;
         check("step_spike", spike_out, exp_spike);
         if (k < NSTP - 1) check("step_busy", busy, 1);
      end
      check("done_pulse", window_done, 1);
      check("done_busy", busy, 0);
      check("done_cnt", spike_cnt, cnt);
      in_valid = 1'b0;
      tick();
      check("done_once", window_done, 0);
      check("idle_ready", in_ready, 1);
      check("idle_spike", spike_out, 0);
      check("idle_cnt_hold", spike_cnt, cnt);
      spikes = cnt;
   endtask

   initial begin
      int s, tot;
      logic [W-1:0] rv;
      bit rm;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_ready", in_ready, 1);
      check("reset_busy", busy, 0);
      check("reset_done", window_done, 0);
      check("reset_spike", spike_out, 0);
      check("reset_cnt", spike_cnt, 0);

      run_window(8'h80, 1'b0, -1, -1, 1'b0, s);
      check("det_80_count", s, 128);
      run_window(8'h00, 1'b0, -1, -1, 1'b0, s);
      check("det_00_count", s, 0);
      run_window(8'hFF, 1'b0, -1, -1, 1'b0, s);
      check("det_FF_count", s, 255);

      tot = 0;
      for (int i = 0; i < 8; i++) begin
         run_window(8'h40, 1'b1, -1, -1, 1'b0, s);
         tot += s;
      end
      check("stoch_40_in_range", (tot >= 448 && tot <= 576), 1);

      run_window(8'h00, 1'b1, -1, -1, 1'b0, s);
      check("stoch_00_count", s, 0);

      run_window(8'h10, 1'b0, 100, -1, 1'b0, s);
      check("abort_partial", s, 6);

      // abort in IDLE alone is ignored and the count holds
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("idle_abort_ready", in_ready, 1);
      check("idle_abort_cnt", spike_cnt, 6);

      run_window(8'hC0, 1'b0, -1, 50, 1'b0, s);
      run_window(8'hC0, 1'b1, -1, -1, 1'b0, s);  // stochastic right after reset checks LFSR seed
      run_window(8'hC0, 1'b0, -1, -1, 1'b0, s);
      check("det_C0_count", s, 192);

      run_window(8'h33, 1'b0, -1, -1, 1'b1, s);
      check("abort_with_accept", s, 8'h33);

      for (int i = 0; i < 6; i++) begin
         rv = W'($urandom);
         rm = 1'($urandom);
         run_window(rv, rm, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NSTP - 1)) : -1,
                    -1, 1'($urandom), s);
      end

      check("accept_count", n_acc, n_acc_exp);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
